// File: rtl/onchip_arb_pkg.sv
// Shared types for the on-chip RAM arbiter: default widths, port index and read-return tag.
package onchip_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic port_idx_t;

    typedef struct packed {
        logic      valid;
        port_idx_t port;
        logic      oor;
    } rd_tag_t;

endpackage

// File: rtl/onchip_arb_grant.sv
// Two-requester grant logic with a bounded-starvation hold counter.
// ONCHIP_ARB_ROUND_ROBIN_EN selects alternating grants under contention instead of m0 priority.
module onchip_arb_grant
    import onchip_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reset_req,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    localparam int unsigned     CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] r_hold_cnt;
    port_idx_t        r_last_grant;

    logic      w_block;
    logic      w_contend;
    port_idx_t w_win;
    port_idx_t w_gport;

    assign w_block   = reset | reset_req;
    assign w_contend = &req;
    assign w_gport   = grant[1];

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    assign w_win = ~r_last_grant;
`else
    // Once the holder has had HOLD_MAX grants in a row, the waiting port takes the next one.
    assign w_win = (r_hold_cnt >= HOLD_LIM) ? ~r_last_grant : 1'b0;
`endif

    always_comb begin
        grant = '0;
        if (!w_block) begin
            if (w_contend) begin
                grant[w_win] = 1'b1;
            end else begin
                grant = req;
            end
        end
    end

    // A switch starts a new run at 1 so the grant that caused it is counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt   <= '0;
            r_last_grant <= 1'b1;
        end else if (|grant) begin
            r_last_grant <= w_gport;
            if (!w_contend) begin
                r_hold_cnt <= '0;
            end else if (w_gport != r_last_grant) begin
                r_hold_cnt <= CNT_W'(1);
            end else if (r_hold_cnt < HOLD_LIM) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM requesters with OOR filtering.
// Build option ONCHIP_ARB_ROUND_ROBIN_EN (in onchip_arb_grant) selects round-robin contention.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUMWORDS = 40000,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken,
    output logic [1:0]          err_sticky,
    input  logic                err_clr
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    port_idx_t         w_gport;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rd;
    logic              w_wr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wd;
    logic              w_oor;
    logic [1:0]        w_err_set;
    logic [DATA_W-1:0] w_rd_data;

    rd_tag_t    r_rd_tag;
    logic [1:0] r_err_sticky;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    onchip_arb_grant #(
        .HOLD_MAX (HOLD_MAX)
    ) u_grant (
        .clk       (clk),
        .reset     (reset),
        .reset_req (reset_req),
        .req       (w_req),
        .grant     (w_grant)
    );

    assign w_gport = w_grant[1];

    // A request with both read and write high is handled as a write only.
    always_comb begin
        w_addr = '0;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_be   = '0;
        w_wd   = '0;
        if (w_grant[0]) begin
            w_addr = m0_address;
            w_wr   = m0_write;
            w_rd   = m0_read & ~m0_write;
            w_be   = m0_byteenable;
            w_wd   = m0_writedata;
        end else if (w_grant[1]) begin
            w_addr = m1_address;
            w_wr   = m1_write;
            w_rd   = m1_read & ~m1_write;
            w_be   = m1_byteenable;
            w_wd   = m1_writedata;
        end
    end

    assign w_oor     = (32'(w_addr) >= NUMWORDS);
    assign w_err_set = w_grant & {2{w_oor}};

    assign mem_address    = w_addr;
    assign mem_chipselect = w_wr & ~w_oor;
    assign mem_write      = mem_chipselect;
    assign mem_byteenable = w_be;
    assign mem_writedata  = w_wd;
    assign mem_clken      = ~reset_req;

    assign m0_waitrequest = ~w_grant[0];
    assign m1_waitrequest = ~w_grant[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_tag     <= '0;
            r_err_sticky <= '0;
        end else begin
            r_rd_tag.valid <= w_rd;
            r_rd_tag.port  <= w_gport;
            r_rd_tag.oor   <= w_oor;
            r_err_sticky   <= (err_clr ? 2'b00 : r_err_sticky) | w_err_set;
        end
    end

    assign w_rd_data        = r_rd_tag.oor ? '0 : mem_readdata;
    assign m0_readdatavalid = r_rd_tag.valid & (r_rd_tag.port == 1'b0);
    assign m1_readdatavalid = r_rd_tag.valid & (r_rd_tag.port == 1'b1);
    assign m0_readdata      = m0_readdatavalid ? w_rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? w_rd_data : '0;
    assign err_sticky       = r_err_sticky;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a small behavioural RAM on the mem_* side.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset_req;
    logic [15:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [15:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic [1:0]  err_sticky;
    logic        err_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [0:63];
    logic [15:0] cap_addr  = '0;
    logic        cap_we    = 1'b0;
    logic        cap_clken = 1'b0;
    logic [3:0]  cap_be    = '0;
    logic [31:0] cap_wd    = '0;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .reset_req        (reset_req),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata),
        .mem_clken        (mem_clken),
        .err_sticky       (err_sticky),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    // RAM port values are captured mid-cycle so the model never races the DUT flops.
    always @(negedge clk) begin
        cap_addr  = mem_address;
        cap_we    = mem_write;
        cap_clken = mem_clken;
        cap_be    = mem_byteenable;
        cap_wd    = mem_writedata;
    end

    always @(posedge clk) begin
        if (cap_clken) begin
            if (cap_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (cap_be[b]) ram[cap_addr[5:0]][8*b +: 8] <= cap_wd[8*b +: 8];
                end
            end
            mem_readdata <= ram[cap_addr[5:0]];
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0;
    endtask

    logic [9:0] exp_g1;
    logic       e, ne, prev, nprev;

    initial begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
        exp_g1 = 10'b1010101010;
`else
        exp_g1 = 10'b1000010000;
`endif
        mem_readdata = '0;
        reset = 1'b1; reset_req = 1'b0; err_clr = 1'b0;
        idle();
        m0_address = '0; m1_address = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = '0; m1_writedata = '0;

        // Reset values
        #2;
        chk("rst_wait0", m0_waitrequest, 1'b1);
        chk("rst_wait1", m1_waitrequest, 1'b1);
        chk("rst_rdv0", m0_readdatavalid, 1'b0);
        chk("rst_rdv1", m1_readdatavalid, 1'b0);
        chk("rst_err", err_sticky, 2'b00);
        chk("rst_maddr", mem_address, 16'h0);
        chk("rst_mcs", mem_chipselect, 1'b0);
        chk("rst_clken", mem_clken, 1'b1);
        cyc();
        reset = 1'b0;

        // Test 1: write then read back
        m0_write = 1'b1; m0_address = 16'h0010; m0_writedata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("t1_wr_wait0", m0_waitrequest, 1'b0);
        chk("t1_wr_cs", mem_chipselect, 1'b1);
        chk("t1_wr_we", mem_write, 1'b1);
        chk("t1_wr_addr", mem_address, 16'h0010);
        chk("t1_wr_wd", mem_writedata, 32'hA5A5A5A5);
        cyc();
        m0_write = 1'b0; m0_read = 1'b1;
        @(negedge clk);
        chk("t1_rd_wait0", m0_waitrequest, 1'b0);
        chk("t1_rd_cs", mem_chipselect, 1'b0);
        chk("t1_rd_rdv_early", m0_readdatavalid, 1'b0);
        cyc();
        m0_read = 1'b0;
        m1_write = 1'b1; m1_address = 16'h0020; m1_writedata = 32'h11112222;
        @(negedge clk);
        chk("t1_rdv0", m0_readdatavalid, 1'b1);
        chk("t1_rdata0", m0_readdata, 32'hA5A5A5A5);
        chk("t1_rdv1_none", m1_readdatavalid, 1'b0);
        chk("t1_m1wr_wait1", m1_waitrequest, 1'b0);
        chk("t1_m1wr_addr", mem_address, 16'h0020);
        cyc();
        m1_write = 1'b0;
        m0_write = 1'b1; m0_address = 16'h0001; m0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_rdv0_gone", m0_readdatavalid, 1'b0);
        cyc();
        idle();

        // Test 2/3: continuous contention from a fresh reset
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 16'h0010;
        m1_read = 1'b1; m1_address = 16'h0020;
        prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e  = exp_g1[i];
            ne = ~e;
            @(negedge clk);
            chk($sformatf("t2_wait0_c%0d", i), m0_waitrequest, e);
            chk($sformatf("t2_wait1_c%0d", i), m1_waitrequest, ne);
            if (i > 0) begin
                nprev = ~prev;
                chk($sformatf("t2_rdv0_c%0d", i), m0_readdatavalid, nprev);
                chk($sformatf("t2_rdv1_c%0d", i), m1_readdatavalid, prev);
                if (prev) chk($sformatf("t2_rdata1_c%0d", i), m1_readdata, 32'h11112222);
                else      chk($sformatf("t2_rdata0_c%0d", i), m0_readdata, 32'hA5A5A5A5);
            end
            prev = e;
            cyc();
        end
        idle();
        @(negedge clk);
        chk("t2_last_rdv1", m1_readdatavalid, exp_g1[9]);
        cyc();

        // Test 4: out-of-range accesses by m1
        m1_write = 1'b1; m1_address = 16'd40000; m1_writedata = 32'h12345678;
        @(negedge clk);
        chk("t4_wr_wait1", m1_waitrequest, 1'b0);
        chk("t4_wr_cs", mem_chipselect, 1'b0);
        chk("t4_wr_we", mem_write, 1'b0);
        cyc();
        m1_write = 1'b0; m1_read = 1'b1; m1_address = 16'd40001;
        @(negedge clk);
        chk("t4_err_after_wr", err_sticky, 2'b10);
        chk("t4_rd_wait1", m1_waitrequest, 1'b0);
        cyc();
        m1_read = 1'b0; m1_write = 1'b1; m1_address = 16'd40000; err_clr = 1'b1;
        @(negedge clk);
        chk("t4_oor_rdv1", m1_readdatavalid, 1'b1);
        chk("t4_oor_rdata1", m1_readdata, 32'h0);
        cyc();
        m1_write = 1'b0;
        @(negedge clk);
        chk("t4_set_wins", err_sticky, 2'b10);
        cyc();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_cleared", err_sticky, 2'b00);

        // Test 5: reset_req with a read in flight
        m0_read = 1'b1; m0_address = 16'h0010;
        @(negedge clk);
        chk("t5_grant0", m0_waitrequest, 1'b0);
        cyc();
        reset_req = 1'b1;
        @(negedge clk);
        chk("t5_block_wait0", m0_waitrequest, 1'b1);
        chk("t5_clken", mem_clken, 1'b0);
        chk("t5_maddr_idle", mem_address, 16'h0);
        chk("t5_inflight_rdv0", m0_readdatavalid, 1'b1);
        chk("t5_inflight_rdata0", m0_readdata, 32'hA5A5A5A5);
        cyc();
        @(negedge clk);
        chk("t5_hold_wait0", m0_waitrequest, 1'b1);
        chk("t5_no_rdv0", m0_readdatavalid, 1'b0);
        cyc();
        reset_req = 1'b0;
        @(negedge clk);
        chk("t5_release_wait0", m0_waitrequest, 1'b0);
        chk("t5_release_clken", mem_clken, 1'b1);
        cyc();
        m0_read = 1'b0;
        @(negedge clk);
        chk("t5_release_rdv0", m0_readdatavalid, 1'b1);
        cyc();

        // Test 6: async reset discards a pending m1 read return
        m1_read = 1'b1; m1_address = 16'd40002;
        @(negedge clk);
        chk("t6_grant1", m1_waitrequest, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_pending_rdv1", m1_readdatavalid, 1'b1);
        chk("t6_err_set", err_sticky, 2'b10);
        reset = 1'b1;
        #1;
        chk("t6_rst_rdv1", m1_readdatavalid, 1'b0);
        chk("t6_rst_err", err_sticky, 2'b00);
        chk("t6_rst_wait0", m0_waitrequest, 1'b1);
        chk("t6_rst_wait1", m1_waitrequest, 1'b1);
        chk("t6_rst_maddr", mem_address, 16'h0);
        chk("t6_rst_cs", mem_chipselect, 1'b0);
        idle();
        cyc();
        reset = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
